// File: rtl/pois_histogram.sv
// rtl/pois_histogram.sv - block-RAM histogram of a fixed-length run of Poisson samples
// Clears all bins, accumulates N samples through a forwarded read-modify-write pipe, then serves reads.
module pois_histogram #(
  parameter int DELAY = 1,
  parameter int BIN_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [23:0]      NSAMPLES,
  input  logic             VALID,
  input  logic [9:0]       SAMPLE,
  input  logic             RD_EN,
  input  logic [BIN_W-1:0] RD_ADDR,
  output logic [CNT_W-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             SATURATED,
  output logic [23:0]      TAKEN
);

  localparam int               NBINS      = 1 << BIN_W;
  localparam logic [BIN_W-1:0] OVF_BIN    = '1;
  localparam logic [9:0]       OVF_SAMPLE = 10'(NBINS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [23:0]      nsamp_q, nsamp_d;
  logic [23:0]      taken_q, taken_d;
  logic             sat_q, sat_d;
  logic [BIN_W-1:0] clr_addr_q, clr_addr_d;
  logic             rd_valid_q;

  logic             s1_v_q, s2_v_q, s3_v_q;
  logic [BIN_W-1:0] s1_bin_q, s2_bin_q, s3_bin_q;
  logic [CNT_W-1:0] s2_cnt_q, s3_cnt_q;

  logic [CNT_W-1:0] mem_q [NBINS];
  logic [CNT_W-1:0] ram_q;

  logic             accept;
  logic [BIN_W-1:0] s0_bin;
  logic [CNT_W-1:0] old_cnt, new_cnt;
  logic             sat_hit;
  logic             we;
  logic [BIN_W-1:0] waddr, raddr;
  logic [CNT_W-1:0] wdata;
  logic             unused_delay;

  assign unused_delay = (DELAY != 0);

  assign accept = (state_q == S_ACCUM) && VALID && (taken_q != nsamp_q);
  assign s0_bin = (SAMPLE < OVF_SAMPLE) ? SAMPLE[BIN_W-1:0] : OVF_BIN;

  // RAM is read-first: the write in flight (s2) and the one just committed (s3)
  // are both invisible to a read issued alongside them, so forward from them.
  always_comb begin
    old_cnt = ram_q;
    if (s2_v_q && (s2_bin_q == s1_bin_q))      old_cnt = s2_cnt_q;
    else if (s3_v_q && (s3_bin_q == s1_bin_q)) old_cnt = s3_cnt_q;
    new_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + 1'b1;
    sat_hit = s1_v_q && (old_cnt == CNT_MAX);
  end

  assign we    = (state_q == S_CLEAR) || s2_v_q;
  assign waddr = (state_q == S_CLEAR) ? clr_addr_q : s2_bin_q;
  assign wdata = (state_q == S_CLEAR) ? '0 : s2_cnt_q;
  assign raddr = (state_q == S_DONE) ? RD_ADDR : s0_bin;

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
    ram_q <= mem_q[raddr];
  end

  always_comb begin
    state_d    = state_q;
    nsamp_d    = nsamp_q;
    taken_d    = taken_q;
    sat_d      = sat_q | sat_hit;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          nsamp_d    = NSAMPLES;
          taken_d    = '0;
          sat_d      = 1'b0;
          clr_addr_d = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == OVF_BIN) state_d = (nsamp_q == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (accept) taken_d = taken_q + 24'd1;
        // Final write commits on this same edge when s1 is empty.
        if ((taken_q == nsamp_q) && !s1_v_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      nsamp_q    <= '0;
      taken_q    <= '0;
      sat_q      <= 1'b0;
      clr_addr_q <= '0;
      rd_valid_q <= 1'b0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s1_bin_q   <= '0;
      s2_bin_q   <= '0;
      s3_bin_q   <= '0;
      s2_cnt_q   <= '0;
      s3_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      nsamp_q    <= nsamp_d;
      taken_q    <= taken_d;
      sat_q      <= sat_d;
      clr_addr_q <= clr_addr_d;
      rd_valid_q <= RD_EN && (state_q == S_DONE);
      s1_v_q     <= accept;
      s1_bin_q   <= s0_bin;
      s2_v_q     <= s1_v_q;
      s2_bin_q   <= s1_bin_q;
      s2_cnt_q   <= new_cnt;
      s3_v_q     <= s2_v_q;
      s3_bin_q   <= s2_bin_q;
      s3_cnt_q   <= s2_cnt_q;
    end
  end

  assign RD_DATA   = rd_valid_q ? ram_q : '0;
  assign RD_VALID  = rd_valid_q;
  assign BUSY      = (state_q == S_CLEAR) || (state_q == S_ACCUM);
  assign DONE      = (state_q == S_DONE);
  assign SATURATED = sat_q;
  assign TAKEN     = taken_q;

endmodule

// File: tb/tb_pois_histogram.sv
// tb/tb_pois_histogram.sv - randomized self-checking bench for pois_histogram
// Reference model is a plain per-bin count array with saturation.
module tb_pois_histogram;
  localparam int BIN_W = 6;
  localparam int CNT_W = 4;
  localparam int NB    = 1 << BIN_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             START = 1'b0;
  logic [23:0]      NSAMPLES = '0;
  logic             VALID = 1'b0;
  logic [9:0]       SAMPLE = '0;
  logic             RD_EN = 1'b0;
  logic [BIN_W-1:0] RD_ADDR = '0;
  logic [CNT_W-1:0] RD_DATA;
  logic             RD_VALID, BUSY, DONE, SATURATED;
  logic [23:0]      TAKEN;

  int checks = 0;
  int errors = 0;
  int exp_bin [NB];
  int m_n, m_taken;
  bit m_sat;

  pois_histogram #(.DELAY(1), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .NSAMPLES(NSAMPLES),
    .VALID(VALID), .SAMPLE(SAMPLE), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY), .DONE(DONE),
    .SATURATED(SATURATED), .TAKEN(TAKEN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_start(input int n);
    for (int i = 0; i < NB; i++) exp_bin[i] = 0;
    m_n = n;
    m_taken = 0;
    m_sat = 0;
  endtask

  task automatic model_add(input int s);
    int b;
    b = (s < NB - 1) ? s : NB - 1;
    if (exp_bin[b] == CMAX) m_sat = 1;
    else exp_bin[b]++;
    m_taken++;
  endtask

  // Called just after the edge that accepted START: checks the clear length.
  task automatic clear_wait(input int n);
    chk("busy_in_clear", BUSY, 1);
    repeat (63) cyc();
    chk("clear_not_done", DONE, 0);
    cyc();
    chk("clear_len_done", DONE, (n == 0));
    chk("clear_len_busy", BUSY, (n != 0));
  endtask

  task automatic start_run(input int n);
    START = 1'b1;
    NSAMPLES = 24'(n);
    cyc();
    START = 1'b0;
    model_start(n);
    clear_wait(n);
  endtask

  task automatic feed(input int s, input bit v);
    VALID = v;
    SAMPLE = 10'(s);
    cyc();
    if (v && m_taken < m_n) model_add(s);
    VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!DONE && k < 40) begin
      cyc();
      k++;
    end
    chk(tag, DONE, 1);
  endtask

  task automatic check_bins(input string tag);
    chk({tag, " taken"}, TAKEN, m_taken);
    chk({tag, " sat"}, SATURATED, m_sat);
    for (int i = 0; i < NB; i++) begin
      RD_EN = 1'b1;
      RD_ADDR = BIN_W'(i);
      cyc();
      chk($sformatf("%s rdv%0d", tag, i), RD_VALID, 1);
      chk($sformatf("%s bin%0d", tag, i), RD_DATA, exp_bin[i]);
    end
    RD_EN = 1'b0;
    cyc();
    chk({tag, " rdv_off"}, RD_VALID, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, guard;
    #12;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sat", SATURATED, 0);
    chk("rst_rdv", RD_VALID, 0);
    chk("rst_taken", TAKEN, 0);
    chk("rst_rddata", RD_DATA, 0);
    RESET_N = 1'b1;
    cyc();

    start_run(8);
    for (int i = 0; i < 8; i++) feed(3, 1);
    wait_done("t1_done");
    check_bins("t1");

    start_run(6);
    feed(5, 1); feed(5, 1); feed(7, 1); feed(5, 1); feed(7, 1); feed(7, 1);
    cyc();
    chk("t2_done_early", DONE, 0);
    cyc();
    chk("t2_done_at2", DONE, 1);
    check_bins("t2");

    start_run(4);
    feed(62, 1); feed(63, 1); feed(100, 1); feed(1023, 1);
    wait_done("t3_done");
    check_bins("t3");

    start_run(20);
    for (int i = 0; i < 20; i++) feed(0, 1);
    wait_done("t4_done");
    chk("t4_bin0_model", exp_bin[0], 15);
    check_bins("t4");

    start_run(5);
    feed(1, 1); feed(2, 1);
    START = 1'b1;
    NSAMPLES = 24'd1;
    feed(3, 1);
    START = 1'b0;
    chk("t5_busy_after_start", BUSY, 1);
    feed(4, 1); feed(5, 1); feed(6, 1); feed(7, 1);
    wait_done("t5_done");
    check_bins("t5");

    RD_EN = 1'b1;
    RD_ADDR = 6'd3;
    START = 1'b1;
    NSAMPLES = 24'd0;
    cyc();
    START = 1'b0;
    RD_EN = 1'b0;
    chk("t6_rd_at_start_v", RD_VALID, 1);
    chk("t6_rd_at_start_d", RD_DATA, exp_bin[3]);
    model_start(0);
    clear_wait(0);
    check_bins("t6");

    start_run(10);
    feed(2, 1); feed(9, 1);
    RD_EN = 1'b1;
    feed(2, 1);
    chk("t7_rdv_in_accum", RD_VALID, 0);
    RD_EN = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    chk("t7_arst_busy", BUSY, 0);
    chk("t7_arst_done", DONE, 0);
    chk("t7_arst_taken", TAKEN, 0);
    chk("t7_arst_sat", SATURATED, 0);
    chk("t7_arst_rdv", RD_VALID, 0);
    cyc();
    RESET_N = 1'b1;
    cyc();
    chk("t7_idle_done", DONE, 0);
    start_run(0);
    check_bins("t7");

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 40);
      start_run(n);
      guard = 0;
      while (m_taken < m_n && guard < 400) begin
        if ($urandom_range(0, 4) == 0) s = $urandom_range(0, 1023);
        else s = $urandom_range(58, 66);
        feed(s, $urandom_range(0, 3) != 0);
        guard++;
      end
      if (n != 0) feed(1, 1);
      wait_done($sformatf("rnd%0d_done", r));
      check_bins($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
